// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester register-file write arbiter with pending-write lookup
//
// Purpose:
//   Accepts write requests from two independent requesters into one holding
//   entry each, and retires at most one entry per cycle onto a registered
//   register-file write port. Ties are broken round-robin. Writes to
//   register 0 are consumed but never asserted on regWrite. A combinational
//   lookup reports whether a write to a given register is still outstanding.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid/ready         request handshake for requester N (N = 0, 1)
//   reqN_addr/data           destination register and write data
//   regWrite/writeReg/       registered register-file write port
//   writeData
//   lookup_addr              register queried for an outstanding write
//   lookup_pending           write to lookup_addr held in an entry or on the port
module regfile_write_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          regWrite,
  output logic [AW-1:0] writeReg,
  output logic [DW-1:0] writeData,
  input  logic [AW-1:0] lookup_addr,
  output logic          lookup_pending
);

  logic          full0_q, full0_d;
  logic          full1_q, full1_d;
  logic [AW-1:0] addr0_q, addr0_d;
  logic [AW-1:0] addr1_q, addr1_d;
  logic [DW-1:0] data0_q, data0_d;
  logic [DW-1:0] data1_q, data1_d;
  logic          last_q, last_d;
  logic          regwrite_q, regwrite_d;
  logic [AW-1:0] write_reg_q, write_reg_d;
  logic [DW-1:0] write_data_q, write_data_d;

  logic grant0, grant1;
  logic acc0, acc1;

  // Grants look only at entry state and the pointer, so ready never
  // depends on valid. When both entries are full, the one not served last wins.
  assign grant0 = full0_q & (~full1_q | last_q);
  assign grant1 = full1_q & (~full0_q | ~last_q);

  // An entry can accept a new request in the same cycle it is being retired.
  assign req0_ready = ~full0_q | grant0;
  assign req1_ready = ~full1_q | grant1;

  assign acc0 = req0_valid & req0_ready;
  assign acc1 = req1_valid & req1_ready;

  assign regWrite  = regwrite_q;
  assign writeReg  = write_reg_q;
  assign writeData = write_data_q;

  // Register 0 is never written, so it is never reported as pending.
  assign lookup_pending = (lookup_addr != '0) &&
                          ((full0_q    && (addr0_q     == lookup_addr)) ||
                           (full1_q    && (addr1_q     == lookup_addr)) ||
                           (regwrite_q && (write_reg_q == lookup_addr)));

  always_comb begin
    full0_d      = full0_q;
    full1_d      = full1_q;
    addr0_d      = addr0_q;
    addr1_d      = addr1_q;
    data0_d      = data0_q;
    data1_d      = data1_q;
    last_d       = last_q;
    regwrite_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;

    // A same-edge acceptance takes priority over the retire so the entry stays full.
    if (acc0) begin
      full0_d = 1'b1;
      addr0_d = req0_addr;
      data0_d = req0_data;
    end else if (grant0) begin
      full0_d = 1'b0;
    end

    if (acc1) begin
      full1_d = 1'b1;
      addr1_d = req1_addr;
      data1_d = req1_data;
    end else if (grant1) begin
      full1_d = 1'b0;
    end

    if (grant0) begin
      write_reg_d  = addr0_q;
      write_data_d = data0_q;
      regwrite_d   = (addr0_q != '0);
      last_d       = 1'b0;
    end else if (grant1) begin
      write_reg_d  = addr1_q;
      write_data_d = data1_q;
      regwrite_d   = (addr1_q != '0);
      last_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full0_q      <= 1'b0;
      full1_q      <= 1'b0;
      addr0_q      <= '0;
      addr1_q      <= '0;
      data0_q      <= '0;
      data1_q      <= '0;
      last_q       <= 1'b1;
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      full0_q      <= full0_d;
      full1_q      <= full1_d;
      addr0_q      <= addr0_d;
      addr1_q      <= addr1_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
      last_q       <= last_d;
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - scoreboard bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0;
  logic          req0_ready;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_data = '0;
  logic          req1_valid = 1'b0;
  logic          req1_ready;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_data = '0;
  logic          regWrite;
  logic [AW-1:0] writeReg;
  logic [DW-1:0] writeData;
  logic [AW-1:0] lookup_addr = 5'd5;
  logic          lookup_pending;

  int n_checks = 0;
  int n_pass   = 0;
  logic [AW+DW-1:0] sb_q[$];

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req0_valid     (req0_valid),
    .req0_ready     (req0_ready),
    .req0_addr      (req0_addr),
    .req0_data      (req0_data),
    .req1_valid     (req1_valid),
    .req1_ready     (req1_ready),
    .req1_addr      (req1_addr),
    .req1_data      (req1_data),
    .regWrite       (regWrite),
    .writeReg       (writeReg),
    .writeData      (writeData),
    .lookup_addr    (lookup_addr),
    .lookup_pending (lookup_pending)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every observed write must match the next expected write, in order.
  always @(negedge clk) begin
    if (!rst && regWrite) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", 64'(regWrite), 64'(0));
      end else begin
        logic [AW+DW-1:0] e;
        e = sb_q.pop_front();
        check("sb_write", 64'({writeReg, writeData}), 64'(e));
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) step();
    check("rst_regwrite", 64'(regWrite), 64'(0));
    check("rst_writereg", 64'(writeReg), 64'(0));
    check("rst_writedata", 64'(writeData), 64'(0));
    check("rst_ready0", 64'(req0_ready), 64'(1));
    check("rst_ready1", 64'(req1_ready), 64'(1));
    check("rst_pending", 64'(lookup_pending), 64'(0));
    rst = 1'b0;
    step();

    // First tie after reset: requester 0 first, then requester 1 next cycle
    sb_q.push_back({5'd3, 32'h11});
    sb_q.push_back({5'd4, 32'h22});
    req0_valid = 1; req0_addr = 5'd3; req0_data = 32'h11;
    req1_valid = 1; req1_addr = 5'd4; req1_data = 32'h22;
    step();
    req0_valid = 0; req1_valid = 0;
    step();
    check("tie1_first", 64'({regWrite, writeReg}), 64'({1'b1, 5'd3}));
    step();
    check("tie1_second", 64'({regWrite, writeReg}), 64'({1'b1, 5'd4}));
    step();

    // Single write with exact one-cycle regWrite pulse
    sb_q.push_back({5'd5, 32'hDEADBEEF});
    req0_valid = 1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    step();
    req0_valid = 0;
    lookup_addr = 5'd5;
    #1;
    check("single_edgeN", 64'(regWrite), 64'(0));
    check("single_pending", 64'(lookup_pending), 64'(1));
    step();
    check("single_write", 64'({regWrite, writeReg, writeData}), 64'({1'b1, 5'd5, 32'hDEADBEEF}));
    step();
    check("single_done", 64'(regWrite), 64'(0));
    check("single_no_pending", 64'(lookup_pending), 64'(0));

    // Second tie: requester 0 was served last, so requester 1 goes first
    sb_q.push_back({5'd10, 32'h44});
    sb_q.push_back({5'd9, 32'h33});
    req0_valid = 1; req0_addr = 5'd9;  req0_data = 32'h33;
    req1_valid = 1; req1_addr = 5'd10; req1_data = 32'h44;
    step();
    req0_valid = 0; req1_valid = 0;
    step();
    check("tie2_first", 64'(writeReg), 64'(10));
    step();
    check("tie2_second", 64'(writeReg), 64'(9));
    step();

    // Back-to-back streaming on requester 1
    for (int i = 0; i < 8; i++) begin
      req1_valid = 1; req1_addr = AW'(i + 1); req1_data = 32'h100 + 32'(i);
      sb_q.push_back({AW'(i + 1), 32'h100 + 32'(i)});
      #1;
      check("stream_ready", 64'(req1_ready), 64'(1));
      step();
      if (i > 0) check("stream_regwrite", 64'(regWrite), 64'(1));
    end
    req1_valid = 0;
    step();
    check("stream_last", 64'({regWrite, writeReg}), 64'({1'b1, 5'd8}));
    step();

    // Address zero is consumed silently
    req0_valid = 1; req0_addr = 5'd0; req0_data = 32'hFFFFFFFF;
    step();
    req0_valid = 0;
    lookup_addr = 5'd0;
    #1;
    check("zero_pending", 64'(lookup_pending), 64'(0));
    step();
    check("zero_regwrite", 64'(regWrite), 64'(0));
    check("zero_ready", 64'(req0_ready), 64'(1));
    step();
    check("zero_regwrite2", 64'(regWrite), 64'(0));

    // Make requester 1 the last served so requester 0 wins the next tie
    sb_q.push_back({5'd12, 32'h66});
    req1_valid = 1; req1_addr = 5'd12; req1_data = 32'h66;
    step();
    req1_valid = 0;
    repeat (2) step();

    // Requester 1 {7,5} held behind contention, then reset mid-hold
    req0_valid = 1; req0_addr = 5'd6; req0_data = 32'h55;
    req1_valid = 1; req1_addr = 5'd7; req1_data = 32'h5;
    step();
    req0_valid = 0; req1_valid = 0;
    lookup_addr = 5'd7;
    #1;
    check("hold_pending", 64'(lookup_pending), 64'(1));
    check("hold_ready1", 64'(req1_ready), 64'(0));
    rst = 1'b1;
    #1;
    check("mid_rst_regwrite", 64'(regWrite), 64'(0));
    check("mid_rst_pending", 64'(lookup_pending), 64'(0));
    check("mid_rst_ready0", 64'(req0_ready), 64'(1));
    check("mid_rst_ready1", 64'(req1_ready), 64'(1));
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_idle", 64'(regWrite), 64'(0));
    end
    check("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
